// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core's MEM stage and the data-memory responder.
interface dmem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [63:0] addr;
    logic [2:0]  funct3;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        busy;
    logic        ready;
    logic        err;

    // Core side drives requests and observes the response.
    modport master (
        output memread, memwrite, addr, funct3, write_data,
        input  read_data, busy, ready, err
    );

    // Memory side accepts requests and returns the response.
    modport slave (
        input  memread, memwrite, addr, funct3, write_data,
        output read_data, busy, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable little-endian data memory with fixed wait states and a one-cycle ready pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_accept;

    logic            r_op_rd;
    logic            r_op_wr;
    logic [63:0]     r_addr;
    logic [2:0]      r_funct3;
    logic [63:0]     r_wdata;

    logic [7:0]      r_mem [DEPTH_BYTES];
    logic [63:0]     r_read_data;
    logic            r_busy;
    logic            r_ready;
    logic            r_err;

    logic            w_op_rd;
    logic            w_op_wr;
    logic [63:0]     w_addr;
    logic [2:0]      w_funct3;
    logic [63:0]     w_wdata;
    logic [3:0]      w_size;
    logic [64:0]     w_end;
    logic            w_err;
    logic            w_enter_resp;
    logic [AW-1:0]   w_idx [8];
    logic [63:0]     w_raw;
    logic [63:0]     w_load;

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.memread || bus.memwrite) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_enter_resp = (w_next == RESP);
    end

    // With zero latency RESP is entered on the accept edge, so use the live request there.
    always_comb begin
        w_op_rd  = r_op_rd;
        w_op_wr  = r_op_wr;
        w_addr   = r_addr;
        w_funct3 = r_funct3;
        w_wdata  = r_wdata;
        if (r_state == IDLE) begin
            w_op_rd  = bus.memread;
            w_op_wr  = bus.memwrite;
            w_addr   = bus.addr;
            w_funct3 = bus.funct3;
            w_wdata  = bus.write_data;
        end
    end

    // Error detection, byte lane addressing and load extension.
    always_comb begin
        w_size = 4'd1 << w_funct3[1:0];
        w_end  = {1'b0, w_addr} + 65'(w_size);
        w_err  = (w_op_rd && w_op_wr)
              || (w_op_rd && (w_funct3 == 3'b111))
              || (w_op_wr && w_funct3[2])
              || ((w_addr[2:0] & 3'(w_size - 4'd1)) != 3'd0)
              || (w_end > 65'(DEPTH_BYTES));
        w_raw  = '0;
        for (int k = 0; k < 8; k++) begin
            w_idx[k] = AW'(w_addr + 64'(k));
            if (4'(k) < w_size) begin
                w_raw[8*k +: 8] = r_mem[w_idx[k]];
            end
        end
        w_load = w_raw;
        case (w_funct3)
            3'b000:  w_load = {{56{w_raw[7]}},  w_raw[7:0]};
            3'b001:  w_load = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load = {{32{w_raw[31]}}, w_raw[31:0]};
            default: w_load = w_raw;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_rd  <= 1'b0;
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_op_rd  <= bus.memread;
            r_op_wr  <= bus.memwrite;
            r_addr   <= bus.addr;
            r_funct3 <= bus.funct3;
            r_wdata  <= bus.write_data;
        end
    end

    // Registered handshake outputs and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_busy  <= (w_next != IDLE);
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && w_err;
            if (w_enter_resp && w_op_rd && !w_op_wr && !w_err) begin
                r_read_data <= w_load;
            end
        end
    end

    // Byte storage; stores commit on the edge entering RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_enter_resp && w_op_wr && !w_op_rd && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_size) begin
                    r_mem[w_idx[k]] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.busy      = r_busy;
    assign bus.ready     = r_ready;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance share one request stream.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rd;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [2:0]  req_f3;
    logic [63:0] req_wd;

    logic [7:0]  model_mem [DEPTH];
    logic [63:0] model_rd;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.memread    = req_rd;
    assign bus2.memwrite   = req_wr;
    assign bus2.addr       = req_addr;
    assign bus2.funct3     = req_f3;
    assign bus2.write_data = req_wd;
    assign bus0.memread    = req_rd;
    assign bus0.memwrite   = req_wr;
    assign bus0.addr       = req_addr;
    assign bus0.funct3     = req_f3;
    assign bus0.write_data = req_wd;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load value: little-endian byte gather plus sign/zero extension.
    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
        logic [63:0] v;
        int sz;
        sz = 1 << f3[1:0];
        v  = 64'd0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = model_mem[int'(a) + k];
        if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    function automatic logic model_err(input logic rd, input logic wr, input logic [63:0] a,
                                       input logic [2:0] f3);
        int sz;
        sz = 1 << f3[1:0];
        return (rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]) ||
               ((a % 64'(sz)) != 64'd0) || (a > 64'(DEPTH - sz));
    endfunction

    // One complete transaction with timing, data and error checks on both instances.
    task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [2:0] f3, input logic [63:0] wd, input string tag);
        logic        exp_err;
        logic [63:0] exp_rd;
        int          ready_k;
        int          busy_cnt;
        int          sz;
        sz      = 1 << f3[1:0];
        exp_err = model_err(rd, wr, a, f3);
        exp_rd  = model_rd;
        if (rd && !wr && !exp_err) exp_rd = model_load(a, f3);
        ready_k  = -1;
        busy_cnt = 0;
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = a; req_f3 = f3; req_wd = wd;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                chk({tag, ".d0_ready"}, 64'(bus0.ready), 64'd1);
                chk({tag, ".d0_err"},   64'(bus0.err), 64'(exp_err));
                chk({tag, ".d0_rdata"}, bus0.read_data, exp_rd);
            end
            if (k == 2) chk({tag, ".d0_idle"}, 64'({bus0.busy, bus0.ready}), 64'd0);
            if (bus2.busy) busy_cnt++;
            if (bus2.ready) begin
                ready_k = k;
                chk({tag, ".err"},   64'(bus2.err), 64'(exp_err));
                chk({tag, ".rdata"}, bus2.read_data, exp_rd);
                break;
            end
        end
        chk({tag, ".ready_cycle"}, 64'(ready_k), 64'(LAT + 1));
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(LAT + 1));
        @(negedge clk);
        chk({tag, ".after"}, 64'({bus2.busy, bus2.ready}), 64'd0);
        if (wr && !rd && !exp_err)
            for (int k = 0; k < sz; k++) model_mem[int'(a) + k] = wd[8*k +: 8];
        model_rd = exp_rd;
    endtask

    initial begin
        int          pulses;
        logic [63:0] v;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] a;
        int          r;
        int          sz;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req_rd   = 1'b0; req_wr = 1'b0; req_addr = '0; req_f3 = '0; req_wd = '0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
        model_rd = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst.rdata",  bus2.read_data, 64'd0);
        chk("rst.flags",  64'({bus2.busy, bus2.ready, bus2.err}), 64'd0);
        chk("rst.d0",     64'({bus0.busy, bus0.ready, bus0.err}), 64'd0);
        reset = 1'b0;

        access(1'b0, 1'b1, 64'h10, 3'b011, 64'h1122334455667788, "sd10");
        access(1'b1, 1'b0, 64'h10, 3'b011, 64'd0, "ld10");
        access(1'b0, 1'b1, 64'h20, 3'b000, 64'h80, "sb20");
        access(1'b1, 1'b0, 64'h20, 3'b000, 64'd0, "lb20");
        access(1'b1, 1'b0, 64'h20, 3'b100, 64'd0, "lbu20");
        access(1'b1, 1'b0, 64'h20, 3'b001, 64'd0, "lh20");
        access(1'b1, 1'b0, 64'h22, 3'b010, 64'd0, "lw22_misaligned");
        access(1'b0, 1'b1, 64'hFC, 3'b011, 64'hDEADBEEFCAFEF00D, "sdFC_oob");
        access(1'b1, 1'b0, 64'hF8, 3'b011, 64'd0, "ldF8_zero");
        access(1'b0, 1'b1, 64'hF8, 3'b011, 64'h8877665544332211, "sdF8_edge");
        access(1'b1, 1'b0, 64'hFC, 3'b010, 64'd0, "lwFC_edge");
        access(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'b011, 64'd0, "ld_wrap");
        access(1'b1, 1'b1, 64'h08, 3'b011, 64'hFFFFFFFFFFFFFFFF, "rdwr08");
        access(1'b1, 1'b0, 64'h08, 3'b011, 64'd0, "ld08");
        access(1'b1, 1'b0, 64'h10, 3'b111, 64'd0, "ld_f3_111");
        access(1'b0, 1'b1, 64'h10, 3'b100, 64'h5555, "st_f3_1xx");
        access(1'b1, 1'b0, 64'h10, 3'b110, 64'd0, "lwu10");

        // Reset while the LATENCY=2 instance is waiting on a store.
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b1; req_addr = 64'h30; req_f3 = 3'b011; req_wd = 64'hA5A5A5A5A5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b0;
        chk("rstmid.busy_before", 64'(bus2.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid.busy", 64'(bus2.busy), 64'd0);
        chk("rstmid.d0",   64'({bus0.busy, bus0.ready}), 64'd0);
        pulses = 0;
        repeat (2) begin @(negedge clk); if (bus2.ready) pulses++; end
        reset = 1'b0;
        repeat (6) begin @(negedge clk); if (bus2.ready) pulses++; end
        chk("rstmid.no_ready", 64'(pulses), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 8'h00;
        model_rd = 64'd0;
        access(1'b1, 1'b0, 64'h30, 3'b011, 64'd0, "ld30_after_rst");
        access(1'b1, 1'b0, 64'h10, 3'b011, 64'd0, "ld10_after_rst");

        // Randomized traffic, mostly aligned, with some out-of-range and illegal requests.
        for (int t = 0; t < 150; t++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r == 0) || (r < 5);
            wr = (r == 0) || (r >= 5);
            f3 = 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            a  = 64'($urandom_range(0, DEPTH + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
            access(rd, wr, a, f3, {$urandom, $urandom}, $sformatf("rnd%0d", t));
        end

        // Held request on the zero-latency instance is re-accepted every other cycle.
        v = model_load(64'h10, 3'b011);
        @(negedge clk);
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 64'h10; req_f3 = 3'b011;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b.ready%0d", i), 64'(bus0.ready), 64'((i % 2) == 0));
            chk($sformatf("b2b.busy%0d", i),  64'(bus0.busy),  64'((i % 2) == 0));
        end
        @(negedge clk);
        req_rd = 1'b0;
        repeat (12) @(negedge clk);
        model_rd = v;
        chk("b2b.d0_rdata", bus0.read_data, v);
        chk("b2b.rdata",    bus2.read_data, v);
        chk("b2b.idle",     64'({bus2.busy, bus0.busy}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
